multi_clk_gate_ctrl: RTL
========================

MULTI_CLK_GATE_CTRL -- requirements
Module: multi_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independently gated clock channels (1..16).
REQ-002 SHALL have parameter IDLE_W, default 8, width of the idle-hysteresis threshold.
REQ-003 SHALL have parameter WAKE_CYCLES, default 2, cycles spent in WAKE before a channel reports ready (1..15).
REQ-004 SHALL have port clk, input, 1, source clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port busy, input, NUM_CH, per-channel activity request.
REQ-007 SHALL have port force_on, input, NUM_CH, per-channel software override that keeps the clock running.
REQ-008 SHALL have port idle_thresh, input, IDLE_W, idle cycles required before gating off; shared by all channels.
REQ-009 SHALL have port scan_en, input, 1, test override that makes every gclk follow clk.
REQ-010 SHALL have port gclk, output, NUM_CH, gated clocks.
REQ-011 SHALL have port ch_on, output, NUM_CH, per-channel flag meaning the clock is guaranteed running.
REQ-012 SHALL have port wake_cnt, output, 16, saturating count of OFF->WAKE transitions.

Function
REQ-013 SHALL implement one FSM per channel with states OFF, WAKE, ON and DRAIN; the channel's request is req = busy | force_on.
REQ-014 OFF with req=1 SHALL go to WAKE on the next edge; OFF with req=0 SHALL stay in OFF.
REQ-015 WAKE SHALL last exactly WAKE_CYCLES cycles and then go to ON unconditionally; req dropping during WAKE SHALL NOT abort the wake.
REQ-016 ON with req=0 and idle_thresh!=0 SHALL go to DRAIN and load the idle counter with idle_thresh; ON with req=0 and idle_thresh==0 SHALL go directly to OFF.
REQ-017 The idle_thresh value SHALL be sampled only on entry to DRAIN; changes to idle_thresh during DRAIN SHALL be ignored.
REQ-018 DRAIN SHALL last idle_thresh cycles and then go to OFF; req=1 during any DRAIN cycle SHALL return the channel to ON on the next edge, with no cycle of clock loss.
REQ-019 The registered enable en_q[i] SHALL be 1 in WAKE, ON and DRAIN, and 0 in OFF.
REQ-020 Gating SHALL be glitch-free: a transparent-low latch captures (en_q[i] | scan_en), and gclk[i] = clk & latch_out[i].
REQ-021 The first gclk rising edge after a wake SHALL occur at the clk edge following the edge at which en_q rises.
REQ-022 ch_on[i] SHALL be a registered output equal to 1 exactly while the channel is in ON or DRAIN.
REQ-023 scan_en SHALL NOT alter FSM state, ch_on or wake_cnt.
REQ-024 wake_cnt SHALL add the number of channels making an OFF->WAKE transition in a cycle (0..NUM_CH), saturating at 0xFFFF with no wrap.
REQ-025 Channels SHALL be fully independent; simultaneous transitions on any channels SHALL be legal.

Reset
REQ-026 rst_n low SHALL asynchronously force every FSM to OFF, en_q=0, all latches cleared, gclk=0, ch_on=0, wake_cnt=0 and idle counters=0, including mid-WAKE or mid-DRAIN.
REQ-027 After rst_n deasserts, the first state change SHALL occur on a rising clk edge.

Verification
REQ-028 Bench SHALL cover: NUM_CH=4, WAKE_CYCLES=2; busy[0] rises before edge 0 -> en_q[0]=1 after edge 0, first gclk[0] pulse at edge 1, ch_on[0]=1 after edge 2, wake_cnt=1.
REQ-029 Bench SHALL cover: idle_thresh=3, busy[0] falls while ON -> ch_on[0] stays 1 for 1 ON + 3 DRAIN cycles, then 0, and gclk[0] stays low afterwards.
REQ-030 Bench SHALL cover: busy[0] reasserted in the 2nd DRAIN cycle -> ON on the next edge, gclk[0] continuous, wake_cnt unchanged.
REQ-031 Bench SHALL cover: idle_thresh=0, force_on[1] pulsed high for 1 cycle -> channel 1 takes WAKE x2, then ON, then OFF with no DRAIN.
REQ-032 Bench SHALL cover: all channels OFF and scan_en=1 -> all 4 gclk toggle with clk while ch_on=0; scan_en=0 -> gclk low with no runt pulse.
REQ-033 Bench SHALL cover: wake_cnt preloaded to 0xFFFD, then 4 simultaneous wakes -> 0xFFFF; rst_n low mid-ON -> gclk=0 immediately, wake_cnt=0.
REQ-034 Bench SHALL include concurrent assertions: state OFF and scan_en=0 -> gclk low; ch_on high -> gclk equals clk.

Source files
------------

// File: rtl/multi_clk_gate_ctrl.sv
// Multi-channel clock gate controller: per-channel OFF/WAKE/ON/DRAIN FSM with
// idle hysteresis, glitch-free latch-based gating and a saturating wake counter.

module mcg_ch #(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [IDLE_W-1:0] idle_thresh,
  output logic              en_q,
  output logic              ch_on_q,
  output logic              wake_evt
);
  typedef enum logic [1:0] {OFF, WAKE, ON, DRAIN} state_e;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              en_d, ch_on_d;

  assign wake_evt = (state_q == OFF) && req;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idle_d  = idle_q;
    case (state_q)
      OFF: if (req) begin
        state_d = WAKE;
        wcnt_d  = WAKE_LAST;
      end
      // wake always runs to completion, regardless of req
      WAKE: if (wcnt_q == 4'd0) state_d = ON;
            else wcnt_d = wcnt_q - 4'd1;
      ON: if (!req) begin
        if (idle_thresh == '0) state_d = OFF;
        else begin
          state_d = DRAIN;
          idle_d  = idle_thresh;
        end
      end
      DRAIN: if (req) begin
        state_d = ON;
        idle_d  = '0;
      end else if (idle_q <= IDLE_W'(1)) begin
        state_d = OFF;
        idle_d  = '0;
      end else begin
        idle_d = idle_q - IDLE_W'(1);
      end
      default: state_d = OFF;
    endcase
    en_d    = (state_d != OFF);
    ch_on_d = (state_d == ON) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      wcnt_q  <= '0;
      idle_q  <= '0;
      en_q    <= 1'b0;
      ch_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idle_q  <= idle_d;
      en_q    <= en_d;
      ch_on_q <= ch_on_d;
    end
  end
endmodule

module multi_clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] busy,
  input  logic [NUM_CH-1:0] force_on,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              scan_en,
  output logic [NUM_CH-1:0] gclk,
  output logic [NUM_CH-1:0] ch_on,
  output logic [15:0]       wake_cnt
);
  logic [NUM_CH-1:0] en_q, ch_on_q, wake_evt, gate_lat;
  logic [15:0]       wake_cnt_q, wake_cnt_d;
  logic [4:0]        wake_sum;
  logic [16:0]       wake_ext;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mcg_ch #(.IDLE_W(IDLE_W), .WAKE_CYCLES(WAKE_CYCLES)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (busy[i] | force_on[i]),
      .idle_thresh (idle_thresh),
      .en_q        (en_q[i]),
      .ch_on_q     (ch_on_q[i]),
      .wake_evt    (wake_evt[i])
    );
  end

  // Transparent while clk is low, so the enable is stable across the high phase.
  always_latch begin
    if (!rst_n)    gate_lat = '0;
    else if (!clk) gate_lat = en_q | {NUM_CH{scan_en}};
  end

  assign gclk     = {NUM_CH{clk}} & gate_lat;
  assign ch_on    = ch_on_q;
  assign wake_cnt = wake_cnt_q;

  always_comb begin
    wake_sum = '0;
    for (int i = 0; i < NUM_CH; i++) wake_sum = wake_sum + {4'b0, wake_evt[i]};
    wake_ext   = {1'b0, wake_cnt_q} + {12'b0, wake_sum};
    wake_cnt_d = wake_ext[16] ? 16'hFFFF : wake_ext[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wake_cnt_q <= '0;
    else        wake_cnt_q <= wake_cnt_d;
  end
endmodule
